// File: rtl/uart_cmd_pkg.sv
// Shared types and default constants for the UART command frame controller.
// Checksum support is selected by the UART_CMD_CHECKSUM_EN macro in uart_cmd_ctrl.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         MAX_LEN_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        ADDR,
        LEN,
        PAYLOAD,
        CHECK,
        HOLD
    } state_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] addr;
        logic [7:0] len;
    } cmd_t;

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; contents only matter once a frame fills them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Indices past DEPTH (non power-of-two depths) read as zero instead of X.
    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame-level command controller behind the UART receiver: sync hunt, frame assembly,
// valid/ready hand-off and error pulses. Define UART_CMD_CHECKSUM_EN to require the checksum byte.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int          MAX_LEN        = MAX_LEN_DEF,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000
) (
    input  logic                       uart_clock,
    input  logic                       uart_reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [7:0]                 cmd_opcode,
    output logic [7:0]                 cmd_addr,
    output logic [7:0]                 cmd_len,
    input  logic [$clog2(MAX_LEN)-1:0] pl_rd_addr,
    output logic [7:0]                 pl_rd_data,
    output logic                       err_checksum,
    output logic                       err_length,
    output logic                       err_timeout,
    output logic                       err_overrun,
    output logic [15:0]                frame_count
);

    localparam int         IDX_W     = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHECK;
    logic [7:0] csum;
`else
    localparam state_t AFTER_DATA = HOLD;
`endif

    state_t           state;
    cmd_t             cmd;
    logic             rx_valid_q;
    logic [IDX_W-1:0] wr_idx;
    logic [23:0]      tmo_cnt;

    logic strobe;
    logic in_frame;
    logic tmo_expired;
    logic last_payload;
    logic buf_we;

    // A new byte is the rising edge of rx_valid; the held level never counts twice.
    assign strobe       = rx_valid & ~rx_valid_q;
    assign in_frame     = state inside {OPCODE, ADDR, LEN, PAYLOAD, CHECK};
    assign tmo_expired  = in_frame && !strobe && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
    assign last_payload = (8'(wr_idx) + 8'd1) == cmd.len;
    assign buf_we       = strobe && (state == PAYLOAD);

    assign cmd_opcode = cmd.opcode;
    assign cmd_addr   = cmd.addr;
    assign cmd_len    = cmd.len;

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (uart_clock),
        .we      (buf_we),
        .wr_idx  (wr_idx),
        .wr_data (rx_data),
        .rd_addr (pl_rd_addr),
        .rd_data (pl_rd_data)
    );

`ifdef UART_CMD_CHECKSUM_EN
    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            csum <= 8'h00;
        end else if (strobe) begin
            if (state == IDLE) begin
                csum <= 8'h00;
            end else if (state inside {OPCODE, ADDR, LEN, PAYLOAD}) begin
                csum <= csum ^ rx_data;
            end
        end
    end
`else
    assign err_checksum = 1'b0;
`endif

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state       <= IDLE;
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            rx_valid_q  <= 1'b0;
            wr_idx      <= '0;
            tmo_cnt     <= '0;
            err_length  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            err_checksum <= 1'b0;
`endif
            frame_count <= '0;
        end else begin
            rx_valid_q  <= rx_valid;
            err_length  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            err_checksum <= 1'b0;
`endif
            if (strobe || !in_frame) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end

            if (tmo_expired) begin
                err_timeout <= 1'b1;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (strobe && rx_data == SYNC_BYTE) state <= OPCODE;
                    end
                    OPCODE: begin
                        if (strobe) begin
                            cmd.opcode <= rx_data;
                            state      <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (strobe) begin
                            cmd.addr <= rx_data;
                            state    <= LEN;
                        end
                    end
                    LEN: begin
                        if (strobe) begin
                            if (rx_data == 8'h00) begin
                                cmd.len   <= 8'h00;
                                state     <= AFTER_DATA;
                                cmd_valid <= (AFTER_DATA == HOLD);
                            end else if (rx_data > MAX_LEN_B) begin
                                err_length <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                cmd.len <= rx_data;
                                wr_idx  <= '0;
                                state   <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (strobe) begin
                            wr_idx <= wr_idx + IDX_W'(1);
                            if (last_payload) begin
                                state     <= AFTER_DATA;
                                cmd_valid <= (AFTER_DATA == HOLD);
                            end
                        end
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    CHECK: begin
                        if (strobe) begin
                            if (rx_data == csum) begin
                                state     <= HOLD;
                                cmd_valid <= 1'b1;
                            end else begin
                                err_checksum <= 1'b1;
                                state        <= IDLE;
                            end
                        end
                    end
`endif
                    HOLD: begin
                        // Bytes arriving while a command is held are dropped, even on the accept cycle.
                        if (strobe) err_overrun <= 1'b1;
                        if (cmd_ready) begin
                            cmd_valid   <= 1'b0;
                            frame_count <= frame_count + 16'd1;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: table-driven frames plus hand-written timeout,
// overrun and mid-frame reset sequences. Follows UART_CMD_CHECKSUM_EN like the RTL.
module tb_uart_cmd_ctrl;

    localparam int         TMO  = 40;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct packed {
        logic [7:0]       op;
        logic [7:0]       addr;
        logic [7:0]       len;
        logic [15:0][7:0] pl;
        logic             noise;
        logic             corrupt;
        logic             exp_valid;
        logic             exp_len_err;
        logic             exp_csum_err;
    } vec_t;

    logic        uart_clock = 1'b0;
    logic        uart_reset = 1'b0;
    logic [7:0]  rx_data    = 8'h00;
    logic        rx_valid   = 1'b0;
    logic        cmd_ready  = 1'b0;
    logic [3:0]  pl_rd_addr = 4'd0;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode, cmd_addr, cmd_len, pl_rd_data;
    logic        err_checksum, err_length, err_timeout, err_overrun;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fc   = 0;
    int cyc      = 0;
    int seen_csum = 0, seen_len = 0, seen_tmo = 0, seen_ovr = 0;
    int tmo_cyc  = 0;
    int b_csum, b_len, b_tmo, b_ovr;

    uart_cmd_ctrl #(
        .TIMEOUT_CYCLES (24'(TMO))
    ) dut (
        .uart_clock   (uart_clock),
        .uart_reset   (uart_reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .pl_rd_addr   (pl_rd_addr),
        .pl_rd_data   (pl_rd_data),
        .err_checksum (err_checksum),
        .err_length   (err_length),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .frame_count  (frame_count)
    );

    always #5 uart_clock = ~uart_clock;

    always @(posedge uart_clock) cyc <= cyc + 1;

    // Error pulses are counted on the falling edge, half a cycle away from the DUT update.
    always @(negedge uart_clock) begin
        if (err_checksum) seen_csum++;
        if (err_length)   seen_len++;
        if (err_overrun)  seen_ovr++;
        if (err_timeout) begin
            seen_tmo++;
            tmo_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        b_csum = seen_csum;
        b_len  = seen_len;
        b_tmo  = seen_tmo;
        b_ovr  = seen_ovr;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge uart_clock);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (2) @(negedge uart_clock);
        rx_valid = 1'b0;
        @(negedge uart_clock);
    endtask

    // With manual_last set, the final byte is driven by hand to check the cmd_valid rise cycle.
    task automatic send_frame(input vec_t v, input bit manual_last);
        logic [7:0] q[$];
        logic [7:0] cs;
        if (v.noise) q.push_back(8'h5C);
        q.push_back(SYNC);
        q.push_back(v.op);
        q.push_back(v.addr);
        q.push_back(v.len);
        cs = v.op ^ v.addr ^ v.len;
        if (v.len <= 8'd16) begin
            for (int i = 0; i < int'(v.len); i++) begin
                q.push_back(v.pl[i]);
                cs = cs ^ v.pl[i];
            end
`ifdef UART_CMD_CHECKSUM_EN
            q.push_back(cs ^ {7'd0, v.corrupt});
`endif
        end
        for (int i = 0; i < q.size() - 1; i++) send_byte(q[i]);
        if (manual_last) begin
            @(negedge uart_clock);
            rx_data  = q[q.size() - 1];
            rx_valid = 1'b1;
            check("valid low before last strobe", cmd_valid, 0);
            @(negedge uart_clock);
            check("valid rises after last strobe", cmd_valid, 1);
            @(negedge uart_clock);
            rx_valid = 1'b0;
            @(negedge uart_clock);
        end else begin
            send_byte(q[q.size() - 1]);
        end
    endtask

    task automatic accept(input string name);
        @(negedge uart_clock);
        cmd_ready = 1'b1;
        @(negedge uart_clock);
        cmd_ready = 1'b0;
        exp_fc++;
        check({name, " valid drops"}, cmd_valid, 0);
        check({name, " frame_count"}, frame_count, exp_fc);
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] len,
                                input logic ev, input logic el, input logic ec);
        vec_t v;
        v = '0;
        v.op = op;  v.addr = addr;  v.len = len;
        v.exp_valid = ev;  v.exp_len_err = el;  v.exp_csum_err = ec;
        return v;
    endfunction

    vec_t vecs[$];
    vec_t v;

    initial begin
        // Frame table.
        v = mk(8'h01, 8'h10, 8'h02, 1, 0, 0);
        v.pl[0] = 8'h33;  v.pl[1] = 8'h44;  v.noise = 1'b1;
        vecs.push_back(v);
`ifdef UART_CMD_CHECKSUM_EN
        v = mk(8'h01, 8'h10, 8'h02, 0, 0, 1);
        v.pl[0] = 8'h33;  v.pl[1] = 8'h44;  v.corrupt = 1'b1;
        vecs.push_back(v);
`endif
        v = mk(8'h02, 8'h20, 8'h03, 1, 0, 0);
        v.pl[0] = 8'hAA;  v.pl[1] = 8'hA5;  v.pl[2] = 8'h0F;
        vecs.push_back(v);
        vecs.push_back(mk(8'h07, 8'h00, 8'h11, 0, 1, 0));
        vecs.push_back(mk(8'h07, 8'h00, 8'h00, 1, 0, 0));
        v = mk(8'h09, 8'hF0, 8'h10, 1, 0, 0);
        for (int i = 0; i < 16; i++) v.pl[i] = 8'(i * 7 + 3);
        vecs.push_back(v);

        // Reset state.
        repeat (3) @(negedge uart_clock);
        check("reset cmd_valid", cmd_valid, 0);
        check("reset opcode", cmd_opcode, 0);
        check("reset addr", cmd_addr, 0);
        check("reset len", cmd_len, 0);
        check("reset frame_count", frame_count, 0);
        check("reset errors", {err_checksum, err_length, err_timeout, err_overrun}, 0);
        uart_reset = 1'b1;
        @(negedge uart_clock);

        for (int n = 0; n < vecs.size(); n++) begin
            snap();
            send_frame(vecs[n], 1'b0);
            repeat (2) @(negedge uart_clock);
            check($sformatf("v%0d cmd_valid", n), cmd_valid, vecs[n].exp_valid);
            check($sformatf("v%0d err_length", n), seen_len - b_len, vecs[n].exp_len_err);
            check($sformatf("v%0d err_checksum", n), seen_csum - b_csum, vecs[n].exp_csum_err);
            check($sformatf("v%0d err_timeout", n), seen_tmo - b_tmo, 0);
            if (vecs[n].exp_valid) begin
                check($sformatf("v%0d opcode", n), cmd_opcode, vecs[n].op);
                check($sformatf("v%0d addr", n), cmd_addr, vecs[n].addr);
                check($sformatf("v%0d len", n), cmd_len, vecs[n].len);
                for (int i = 0; i < int'(vecs[n].len); i++) begin
                    pl_rd_addr = 4'(i);
                    #1;
                    check($sformatf("v%0d payload[%0d]", n, i), pl_rd_data, vecs[n].pl[i]);
                end
                accept($sformatf("v%0d", n));
            end
        end

        // Timeout: A5 01 with rx_valid then held high for 2*TMO cycles.
        snap();
        send_byte(SYNC);
        @(negedge uart_clock);
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        b_csum   = cyc;
        repeat (2 * TMO) @(negedge uart_clock);
        rx_valid = 1'b0;
        @(negedge uart_clock);
        check("timeout pulse count", seen_tmo - b_tmo, 1);
        check("timeout latency", tmo_cyc - b_csum, TMO + 1);
        check("timeout opcode taken", cmd_opcode, 8'h01);
        check("timeout no valid", cmd_valid, 0);
        v = mk(8'h04, 8'h44, 8'h01, 1, 0, 0);
        v.pl[0] = 8'h5A;
        send_frame(v, 1'b0);
        repeat (2) @(negedge uart_clock);
        check("after timeout valid", cmd_valid, 1);
        check("after timeout addr", cmd_addr, 8'h44);
        accept("after timeout");

        // Held command: no timeout while held, overrun leaves fields intact.
        v = mk(8'h3C, 8'h81, 8'h01, 1, 0, 0);
        v.pl[0] = 8'h99;
        snap();
        send_frame(v, 1'b1);
        repeat (2 * TMO) @(negedge uart_clock);
        check("hold no timeout", seen_tmo - b_tmo, 0);
        check("hold still valid", cmd_valid, 1);
        send_byte(8'h5A);
        @(negedge uart_clock);
        check("overrun pulse", seen_ovr - b_ovr, 1);
        check("overrun valid kept", cmd_valid, 1);
        check("overrun fields kept", {cmd_opcode, cmd_addr, cmd_len}, 24'h3C8101);
        pl_rd_addr = 4'd0;
        #1;
        check("overrun payload kept", pl_rd_data, 8'h99);

        // Strobe and cmd_ready in the same cycle: accepted and overrun together.
        snap();
        @(negedge uart_clock);
        rx_data   = 8'h77;
        rx_valid  = 1'b1;
        cmd_ready = 1'b1;
        @(negedge uart_clock);
        cmd_ready = 1'b0;
        rx_valid  = 1'b0;
        exp_fc++;
        @(negedge uart_clock);
        check("same-cycle valid drops", cmd_valid, 0);
        check("same-cycle frame_count", frame_count, exp_fc);
        check("same-cycle overrun", seen_ovr - b_ovr, 1);

        // Reset in the middle of a frame.
        snap();
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h10);
        uart_reset = 1'b0;
        #2;
        check("mid reset cmd_valid", cmd_valid, 0);
        check("mid reset fields", {cmd_opcode, cmd_addr, cmd_len}, 0);
        check("mid reset frame_count", frame_count, 0);
        @(negedge uart_clock);
        uart_reset = 1'b1;
        exp_fc = 0;
        @(negedge uart_clock);
        check("mid reset no errors", (seen_csum - b_csum) + (seen_len - b_len)
                                   + (seen_tmo - b_tmo) + (seen_ovr - b_ovr), 0);
        v = mk(8'h01, 8'h10, 8'h02, 1, 0, 0);
        v.pl[0] = 8'h33;  v.pl[1] = 8'h44;
        send_frame(v, 1'b0);
        repeat (2) @(negedge uart_clock);
        check("post reset valid", cmd_valid, 1);
        check("post reset fields", {cmd_opcode, cmd_addr, cmd_len}, 24'h011002);
        accept("post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame-level command controller behind the 8-bit UART receiver in the MRAM statistical-data-collection path. It consumes received bytes, hunts for a sync byte, and assembles a command frame: opcode, address, length, payload and an optional checksum. It presents the complete command to the test sequencer over a valid/ready handshake and flags malformed, stalled or overrun traffic.

## Interface

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes (1..255).
- TIMEOUT_CYCLES, 24'd100000, inter-byte timeout in uart_clock cycles (1 ms at 100 MHz).

Ports:
- uart_clock  in  1  sole clock.
- uart_reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  receiver valid, held high from end of byte until the next start bit.
- cmd_valid  out  1  complete command held for the sequencer.
- cmd_ready  in  1  sequencer accepts the command.
- cmd_opcode  out  8  opcode of the held command.
- cmd_addr  out  8  address of the held command.
- cmd_len  out  8  payload byte count of the held command.
- pl_rd_addr  in  $clog2(MAX_LEN)  payload read index.
- pl_rd_data  out  8  payload byte at pl_rd_addr, combinational.
- err_checksum  out  1  one-cycle pulse.
- err_length  out  1  one-cycle pulse.
- err_timeout  out  1  one-cycle pulse.
- err_overrun  out  1  one-cycle pulse.
- frame_count  out  16  count of accepted commands, wraps at 16'hFFFF to 0.

## Operation

- Byte strobe: rx_valid & ~rx_valid_q, where rx_valid_q is rx_valid registered and reset to 0. The level of rx_valid is never treated as a new byte.
- States and transitions (all on strobe unless stated):
  - IDLE -> OPCODE when rx_data == SYNC_BYTE. Other bytes are ignored.
  - OPCODE -> ADDR.
  - ADDR -> LEN.
  - LEN -> PAYLOAD if the byte is in 1..MAX_LEN.
  - LEN -> CHECK if the byte is 0.
  - LEN > MAX_LEN: pulse err_length and go to IDLE.
  - PAYLOAD: write the byte to buffer[wr_idx] and increment wr_idx. After cmd_len bytes, go to CHECK.
  - CHECK: compare the byte with the running checksum. On match go to HOLD. On mismatch pulse err_checksum and go to IDLE.
  - HOLD: cmd_valid = 1. On cmd_ready, go to IDLE and increment frame_count.
- Running checksum:
  - XOR of opcode, addr, len and all payload bytes.
  - Cleared on entry to OPCODE.
- HOLD with a strobe and no cmd_ready: drop the byte and pulse err_overrun. The held command is unchanged.
- HOLD with a strobe and cmd_ready in the same cycle: the command is accepted, go to IDLE, and the byte is dropped with err_overrun.
- Timeout:
  - The counter clears on every strobe and on entry to OPCODE.
  - It increments in OPCODE..CHECK.
  - At TIMEOUT_CYCLES-1, pulse err_timeout and go to IDLE.
  - If a strobe and expiry fall in the same cycle, the strobe wins.
- cmd_opcode, cmd_addr and cmd_len are registered when their byte is taken. They are stable throughout HOLD.
- pl_rd_data is valid only while cmd_valid = 1.

## Timing

- Reset values:
  - All outputs are 0: cmd_valid, cmd_opcode, cmd_addr, cmd_len, all err_* pulses and frame_count.
  - State is IDLE. rx_valid_q, checksum, timeout counter and wr_idx are 0.
  - Buffer contents are don't-care. pl_rd_data reads whatever the buffer holds.
- cmd_valid rises on the cycle after the strobe of the final frame byte.
- cmd_valid falls on the cycle after cmd_valid & cmd_ready.
- Minimum sync-to-acceptance time: one cycle after the last strobe, plus ready latency.
- Error pulses are exactly one cycle, registered, and assert the cycle after the causing event.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at their reset values. A partial frame is discarded and no error is pulsed.

## Configuration

- UART_CMD_CHECKSUM_EN defined:
  - The CHECK state exists and the checksum byte is required.
  - err_checksum is active.
- UART_CMD_CHECKSUM_EN undefined:
  - There is no CHECK state. Completing the payload (or LEN = 0) goes straight to HOLD.
  - err_checksum is tied to 0.
  - Checksum logic is not built.

## Structure

- Package uart_cmd_pkg holds:
  - the state enum typedef (IDLE, OPCODE, ADDR, LEN, PAYLOAD, CHECK, HOLD);
  - the command struct typedef (opcode, addr, len);
  - default constants for SYNC_BYTE and MAX_LEN.
- Sub-module uart_cmd_buf:
  - MAX_LEN x 8 register-file payload buffer;
  - synchronous write port (we, wr_idx, wr_data);
  - combinational read port.
- The FSM, timeout counter, checksum and counters stay in uart_cmd_ctrl.

## Test plan

- Checksum enabled. Bytes A5 01 10 02 33 44 64 -> cmd_valid with opcode 01, addr 10, len 02. pl_rd_data[0]=33, pl_rd_data[1]=44. After cmd_ready, frame_count = 1.
- Bytes A5 01 10 02 33 44 65 -> err_checksum pulses, no cmd_valid, state IDLE. A following valid frame is accepted.
- Bytes A5 07 00 11 (len 0 > MAX_LEN? no, len = 0x11 with MAX_LEN 16) -> err_length after the len byte. Then A5 07 00 00 07 -> cmd_valid with len 0.
- A5 01, then rx_valid held high for 2*TIMEOUT_CYCLES -> no extra bytes taken and a single err_timeout pulse. Frame abandoned.
- Command held with cmd_ready low and a new byte arrives -> err_overrun pulse, held fields unchanged.
- Reset asserted after A5 01 10 -> all outputs 0. A fresh frame completes normally.
